// File: rtl/loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write port driven by the loader.
interface imem_uart_loader_if;

    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;

    modport master (output imem_we, imem_waddr, imem_wdata);
    modport slave  (input  imem_we, imem_waddr, imem_wdata);

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, mid-bit start re-check, LSB-first shift.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       uart_rx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    rx_state_t        r_state, r_state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic             valid_nxt, ferr_nxt;
    logic             rx_meta, rx_s, rx_prev;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            rx_prev      <= 1'b1;
            r_state      <= R_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_meta      <= uart_rx;
            rx_s         <= rx_meta;
            rx_prev      <= rx_s;
            r_state      <= r_state_nxt;
            cnt          <= cnt_nxt;
            bit_idx      <= bit_idx_nxt;
            rx_valid     <= valid_nxt;
            rx_frame_err <= ferr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_nxt;
    end

    assign rx_data = shreg;

    always_comb begin
        r_state_nxt = r_state;
        cnt_nxt     = cnt + 1'b1;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        valid_nxt   = 1'b0;
        ferr_nxt    = 1'b0;
        case (r_state)
            R_IDLE: begin
                cnt_nxt = '0;
                if (rx_prev && !rx_s) r_state_nxt = R_START;
            end
            R_START: begin
                // A start bit that has gone high again by mid-bit was only a glitch.
                if (cnt == CNT_HALF) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    r_state_nxt = rx_s ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (cnt == CNT_FULL) begin
                    cnt_nxt     = '0;
                    shreg_nxt   = {rx_s, shreg[7:1]};
                    bit_idx_nxt = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) r_state_nxt = R_STOP;
                end
            end
            R_STOP: begin
                if (cnt == CNT_FULL) begin
                    cnt_nxt     = '0;
                    r_state_nxt = R_IDLE;
                    valid_nxt   = rx_s;
                    ferr_nxt    = !rx_s;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

endmodule

// File: rtl/imem_uart_loader.sv
// Frame parser: sync/length/data/checksum over UART, writes instruction memory, gates core reset.
module imem_uart_loader
    import loader_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
    parameter int unsigned BAUD          = 115200,
    parameter int unsigned DEPTH_WORDS   = 1024,
    parameter bit          HOLD_AT_RESET = 1'b0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                uart_rx,
    imem_uart_loader_if.master  imem,
    output logic                core_resetn,
    output logic                busy,
    output logic                load_done,
    output logic                load_error
);

    localparam int CLKS_PER_BIT = int'(CLK_FREQ_HZ / BAUD);

    logic       rx_valid, rx_frame_err;
    logic [7:0] rx_data;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk          (clk),
        .resetn       (resetn),
        .uart_rx      (uart_rx),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_frame_err (rx_frame_err)
    );

    loader_state_t state, state_nxt;
    logic [15:0]   len, len_nxt, widx, widx_nxt;
    logic [1:0]    byte_cnt, byte_cnt_nxt;
    logic [7:0]    chk, chk_nxt;
    logic [23:0]   sh, sh_nxt;
    logic          we_nxt, crst_nxt, busy_nxt, done_nxt, err_nxt;
    logic [31:0]   waddr_nxt, wdata_nxt;
    logic [15:0]   len_rx;
    logic          in_frame;

    assign len_rx   = {rx_data, len[7:0]};
    assign in_frame = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                      (state == ST_DATA)   || (state == ST_CHECK);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= ST_IDLE;
            len             <= '0;
            widx            <= '0;
            byte_cnt        <= '0;
            chk             <= '0;
            imem.imem_we    <= 1'b0;
            imem.imem_waddr <= '0;
            imem.imem_wdata <= '0;
            core_resetn     <= !HOLD_AT_RESET;
            busy            <= 1'b0;
            load_done       <= 1'b0;
            load_error      <= 1'b0;
        end else begin
            state           <= state_nxt;
            len             <= len_nxt;
            widx            <= widx_nxt;
            byte_cnt        <= byte_cnt_nxt;
            chk             <= chk_nxt;
            imem.imem_we    <= we_nxt;
            imem.imem_waddr <= waddr_nxt;
            imem.imem_wdata <= wdata_nxt;
            core_resetn     <= crst_nxt;
            busy            <= busy_nxt;
            load_done       <= done_nxt;
            load_error      <= err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        sh <= sh_nxt;
    end

    always_comb begin
        state_nxt    = state;
        len_nxt      = len;
        widx_nxt     = widx;
        byte_cnt_nxt = byte_cnt;
        chk_nxt      = chk;
        sh_nxt       = sh;
        we_nxt       = 1'b0;
        waddr_nxt    = imem.imem_waddr;
        wdata_nxt    = imem.imem_wdata;
        crst_nxt     = core_resetn;
        busy_nxt     = busy;
        done_nxt     = load_done;
        err_nxt      = load_error;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_nxt = ST_LEN_LO;
                    chk_nxt   = '0;
                    done_nxt  = 1'b0;
                    err_nxt   = 1'b0;
                    crst_nxt  = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            ST_LEN_LO: begin
                if (rx_valid) begin
                    len_nxt   = {8'd0, rx_data};
                    state_nxt = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (rx_valid) begin
                    len_nxt      = len_rx;
                    widx_nxt     = '0;
                    byte_cnt_nxt = '0;
                    if ({16'd0, len_rx} > DEPTH_WORDS) begin
                        state_nxt = ST_ERROR;
                        err_nxt   = 1'b1;
                        busy_nxt  = 1'b0;
                    end else if (len_rx == 16'd0) begin
                        state_nxt = ST_CHECK;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // Bytes 0..2 collect in sh; the 4th completes the word and fires the strobe.
                if (rx_valid) begin
                    chk_nxt      = chk ^ rx_data;
                    byte_cnt_nxt = byte_cnt + 1'b1;
                    sh_nxt       = {rx_data, sh[23:8]};
                    if (byte_cnt == 2'd3) begin
                        we_nxt    = 1'b1;
                        waddr_nxt = {14'd0, widx, 2'b00};
                        wdata_nxt = {rx_data, sh};
                        widx_nxt  = widx + 16'd1;
                        if (widx + 16'd1 == len) state_nxt = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (rx_valid) begin
                    busy_nxt = 1'b0;
                    if (rx_data == chk) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                        crst_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_ERROR;
                        err_nxt   = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (rx_frame_err && in_frame) begin
            state_nxt = ST_ERROR;
            we_nxt    = 1'b0;
            err_nxt   = 1'b1;
            busy_nxt  = 1'b0;
        end
    end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: framed UART stimulus checked against a frame-level reference model.
module tb_imem_uart_loader;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD_R = 100_000;
    localparam int CPB    = CLK_HZ / BAUD_R;
    localparam int DEPTH  = 1024;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic uart_rx = 1'b1;
    logic core_resetn, busy, load_done, load_error;

    imem_uart_loader_if bus ();

    imem_uart_loader #(
        .CLK_FREQ_HZ   (CLK_HZ),
        .BAUD          (BAUD_R),
        .DEPTH_WORDS   (DEPTH),
        .HOLD_AT_RESET (1'b0)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .uart_rx     (uart_rx),
        .imem        (bus),
        .core_resetn (core_resetn),
        .busy        (busy),
        .load_done   (load_done),
        .load_error  (load_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t got_q[$];
    wr_t exp_q[$];
    int  nvec = 0;
    int  nerr = 0;
    logic exp_done = 1'b0, exp_err = 1'b0, exp_crst = 1'b1;

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) got_q.push_back({bus.imem_waddr, bus.imem_wdata});
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d want finish", $time);
        $fatal(1);
    end

    // Reference: walk the byte stream frame by frame, as a receiver of the protocol would.
    task automatic model(input logic [7:0] bs[$]);
        int i;
        int n;
        logic [7:0]  x;
        logic [31:0] w;
        i = 0;
        exp_q.delete();
        while (i < bs.size()) begin
            if (bs[i] != 8'hA5) begin
                i++;
                continue;
            end
            exp_done = 1'b0;
            exp_err  = 1'b0;
            exp_crst = 1'b0;
            n = int'({bs[i+2], bs[i+1]});
            i += 3;
            if (n > DEPTH) begin
                exp_err = 1'b1;
                continue;
            end
            x = 8'h00;
            for (int k = 0; k < n; k++) begin
                w = {bs[i+3], bs[i+2], bs[i+1], bs[i]};
                x = x ^ bs[i] ^ bs[i+1] ^ bs[i+2] ^ bs[i+3];
                exp_q.push_back({32'(k * 4), w});
                i += 4;
            end
            if (bs[i] == x) begin
                exp_done = 1'b1;
                exp_crst = 1'b1;
            end else begin
                exp_err = 1'b1;
            end
            i++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = bad_stop ? 1'b0 : 1'b1;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_stream(input logic [7:0] bs[$]);
        foreach (bs[i]) send_byte(bs[i], 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        nvec++;
        if ({bus.imem_we, busy, load_done, load_error, core_resetn} !== 5'b00001) begin
            nerr++;
            $display("FAIL reset_ctrl: got we/busy/done/err/crst=%b want 00001",
                     {bus.imem_we, busy, load_done, load_error, core_resetn});
        end
        nvec++;
        if ({bus.imem_waddr, bus.imem_wdata} !== 64'd0) begin
            nerr++;
            $display("FAIL reset_bus: got addr=%h data=%h want 0/0", bus.imem_waddr, bus.imem_wdata);
        end
        resetn = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_good_frame();
        logic [7:0] fr[$];
        fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        got_q.delete();
        model(fr);
        send_byte(fr[0], 1'b0);
        nvec++;
        if ({busy, core_resetn, load_done} !== 3'b100) begin
            nerr++;
            $display("FAIL good_after_sync: got busy/crst/done=%b want 100", {busy, core_resetn, load_done});
        end
        for (int i = 1; i < fr.size() - 1; i++) send_byte(fr[i], 1'b0);
        nvec++;
        if ({load_done, core_resetn, busy} !== 3'b001) begin
            nerr++;
            $display("FAIL good_before_chk: got done/crst/busy=%b want 001", {load_done, core_resetn, busy});
        end
        send_byte(fr[fr.size() - 1], 1'b0);
        repeat (3) @(negedge clk);
        nvec++;
        if (got_q.size() != exp_q.size()) begin
            nerr++;
            $display("FAIL good_count: got %0d strobes want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            nvec++;
            if (got_q[i] !== exp_q[i]) begin
                nerr++;
                $display("FAIL good_write%0d: got %h/%h want %h/%h", i,
                         got_q[i].a, got_q[i].d, exp_q[i].a, exp_q[i].d);
            end
        end
        nvec++;
        if ({load_done, load_error, core_resetn, busy, bus.imem_we} !== {exp_done, exp_err, exp_crst, 2'b00}) begin
            nerr++;
            $display("FAIL good_flags: got done/err/crst/busy/we=%b want %b",
                     {load_done, load_error, core_resetn, busy, bus.imem_we}, {exp_done, exp_err, exp_crst, 2'b00});
        end
        nvec++;
        if ({bus.imem_waddr, bus.imem_wdata} !== exp_q[exp_q.size() - 1]) begin
            nerr++;
            $display("FAIL good_hold: got %h/%h want %h", bus.imem_waddr, bus.imem_wdata, exp_q[exp_q.size() - 1]);
        end
    endtask

    task automatic test_bad_chk();
        logic [7:0] fr[$];
        fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
        got_q.delete();
        model(fr);
        send_stream(fr);
        nvec++;
        if (got_q.size() != exp_q.size()) begin
            nerr++;
            $display("FAIL badchk_count: got %0d strobes want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            nvec++;
            if (got_q[i] !== exp_q[i]) begin
                nerr++;
                $display("FAIL badchk_write%0d: got %h/%h want %h/%h", i,
                         got_q[i].a, got_q[i].d, exp_q[i].a, exp_q[i].d);
            end
        end
        nvec++;
        if ({load_done, load_error, core_resetn, busy} !== {exp_done, exp_err, exp_crst, 1'b0}) begin
            nerr++;
            $display("FAIL badchk_flags: got done/err/crst/busy=%b want %b",
                     {load_done, load_error, core_resetn, busy}, {exp_done, exp_err, exp_crst, 1'b0});
        end
    endtask

    task automatic test_len_overflow();
        logic [7:0] fr[$];
        fr = '{8'hA5, 8'h05, 8'h04};
        got_q.delete();
        model(fr);
        send_stream(fr);
        nvec++;
        if (got_q.size() != 0) begin
            nerr++;
            $display("FAIL overflow_strobe: got %0d strobes want 0", got_q.size());
        end
        nvec++;
        if ({load_done, load_error, core_resetn, busy} !== {exp_done, exp_err, exp_crst, 1'b0}) begin
            nerr++;
            $display("FAIL overflow_flags: got done/err/crst/busy=%b want %b",
                     {load_done, load_error, core_resetn, busy}, {exp_done, exp_err, exp_crst, 1'b0});
        end
    endtask

    task automatic test_garbage();
        logic [7:0] fr[$];
        fr = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h00, 8'h00, 8'h00};
        got_q.delete();
        model(fr);
        send_stream(fr);
        nvec++;
        if (got_q.size() != 0) begin
            nerr++;
            $display("FAIL garbage_strobe: got %0d strobes want 0", got_q.size());
        end
        nvec++;
        if ({load_done, load_error, core_resetn, busy} !== {exp_done, exp_err, exp_crst, 1'b0}) begin
            nerr++;
            $display("FAIL garbage_flags: got done/err/crst/busy=%b want %b",
                     {load_done, load_error, core_resetn, busy}, {exp_done, exp_err, exp_crst, 1'b0});
        end
    endtask

    task automatic test_glitch();
        logic [7:0] fr[$];
        logic [31:0] w;
        w = $urandom;
        fr = '{8'hA5, 8'h01, 8'h00, w[7:0], w[15:8], w[23:16], w[31:24],
               w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24]};
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        got_q.delete();
        model(fr);
        send_stream(fr);
        nvec++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            nerr++;
            $display("FAIL glitch_write: got %0d strobes first=%h want 1 strobe %h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 64'd0, exp_q[0]);
        end
        nvec++;
        if ({load_done, load_error, core_resetn} !== {exp_done, exp_err, exp_crst}) begin
            nerr++;
            $display("FAIL glitch_flags: got done/err/crst=%b want %b",
                     {load_done, load_error, core_resetn}, {exp_done, exp_err, exp_crst});
        end
    endtask

    task automatic test_framing();
        got_q.delete();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b1);
        repeat (3) @(negedge clk);
        nvec++;
        if ({load_done, load_error, core_resetn, busy} !== 4'b0100) begin
            nerr++;
            $display("FAIL framing_flags: got done/err/crst/busy=%b want 0100",
                     {load_done, load_error, core_resetn, busy});
        end
        nvec++;
        if (got_q.size() != 0) begin
            nerr++;
            $display("FAIL framing_strobe: got %0d strobes want 0", got_q.size());
        end
        exp_done = 1'b0;
        exp_err  = 1'b1;
        exp_crst = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [7:0] fr[$];
        logic [31:0] w0, w1;
        got_q.delete();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
        #2 resetn = 1'b0;
        #1;
        nvec++;
        if ({bus.imem_we, busy, load_done, load_error, core_resetn} !== 5'b00001 ||
            {bus.imem_waddr, bus.imem_wdata} !== 64'd0) begin
            nerr++;
            $display("FAIL midreset_vals: got we/busy/done/err/crst=%b addr=%h data=%h want 00001/0/0",
                     {bus.imem_we, busy, load_done, load_error, core_resetn}, bus.imem_waddr, bus.imem_wdata);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (30) @(negedge clk);
        nvec++;
        if (got_q.size() != 0) begin
            nerr++;
            $display("FAIL midreset_strobe: got %0d strobes want 0", got_q.size());
        end
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_crst = 1'b1;
        w0 = $urandom;
        w1 = $urandom;
        fr = '{8'hA5, 8'h02, 8'h00, w0[7:0], w0[15:8], w0[23:16], w0[31:24],
               w1[7:0], w1[15:8], w1[23:16], w1[31:24],
               w0[7:0] ^ w0[15:8] ^ w0[23:16] ^ w0[31:24] ^ w1[7:0] ^ w1[15:8] ^ w1[23:16] ^ w1[31:24]};
        model(fr);
        send_stream(fr);
        nvec++;
        if (got_q.size() != exp_q.size()) begin
            nerr++;
            $display("FAIL midreset_reload_count: got %0d strobes want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            nvec++;
            if (got_q[i] !== exp_q[i]) begin
                nerr++;
                $display("FAIL midreset_write%0d: got %h/%h want %h/%h", i,
                         got_q[i].a, got_q[i].d, exp_q[i].a, exp_q[i].d);
            end
        end
        nvec++;
        if ({load_done, load_error, core_resetn} !== {exp_done, exp_err, exp_crst}) begin
            nerr++;
            $display("FAIL midreset_flags: got done/err/crst=%b want %b",
                     {load_done, load_error, core_resetn}, {exp_done, exp_err, exp_crst});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] fr[$];
        logic [7:0] x, b;
        int n;
        for (int it = 0; it < 6; it++) begin
            fr.delete();
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                b = 8'($urandom);
                fr.push_back((b == 8'hA5) ? 8'h00 : b);
            end
            n = int'($urandom_range(0, 4));
            fr.push_back(8'hA5);
            fr.push_back(8'(n));
            fr.push_back(8'h00);
            x = 8'h00;
            for (int k = 0; k < 4 * n; k++) begin
                b = 8'($urandom);
                x ^= b;
                fr.push_back(b);
            end
            fr.push_back(($urandom_range(0, 2) == 0) ? (x ^ 8'($urandom_range(1, 255))) : x);
            got_q.delete();
            model(fr);
            send_stream(fr);
            nvec++;
            if (got_q.size() != exp_q.size()) begin
                nerr++;
                $display("FAIL b2b%0d_count: got %0d strobes want %0d", it, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                nvec++;
                if (got_q[i] !== exp_q[i]) begin
                    nerr++;
                    $display("FAIL b2b%0d_write%0d: got %h/%h want %h/%h", it, i,
                             got_q[i].a, got_q[i].d, exp_q[i].a, exp_q[i].d);
                end
            end
            nvec++;
            if ({load_done, load_error, core_resetn, busy} !== {exp_done, exp_err, exp_crst, 1'b0}) begin
                nerr++;
                $display("FAIL b2b%0d_flags: got done/err/crst/busy=%b want %b", it,
                         {load_done, load_error, core_resetn, busy}, {exp_done, exp_err, exp_crst, 1'b0});
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_bad_chk();
        test_len_overflow();
        test_garbage();
        test_glitch();
        test_framing();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
